// File: rtl/aes_stream_ctrl.sv
// rtl/aes_stream_ctrl.sv - byte-stream frame assembler and sequencer for the iterative AES-128 core
module aes_stream_ctrl #(
  parameter int WDOG_MAX = 63
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic [7:0]   i_RxData,
  input  logic         i_RxValid,
  output logic         o_RxReady,
  output logic [7:0]   o_TxData,
  output logic         o_TxValid,
  input  logic         i_TxReady,
  output logic         o_AesRst_n,
  output logic         o_AesStart,
  output logic         o_AesEnc,
  output logic [127:0] o_AesText,
  output logic [127:0] o_AesKey,
  input  logic [127:0] i_AesData,
  input  logic         i_AesDone,
  output logic         o_Busy,
  output logic         o_Err
);

  localparam int WDW = $clog2(WDOG_MAX + 1);

  typedef enum logic [2:0] {
    ST_CMD, ST_KEY, ST_TEXT, ST_CORE_RST, ST_START, ST_WAIT, ST_SEND
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q;
  logic [WDW-1:0] wdog_q;
  logic           key_valid_q;
  logic           has_key_q;
  logic           aes_enc_q;
  logic [127:0]   text_q, key_q, result_q;
  logic           err_q, start_q, core_rst_n_q;

  logic rx_fire, tx_fire, cmd_bad, cnt_last, wdog_tc;

  assign rx_fire  = i_RxValid & o_RxReady;
  assign tx_fire  = o_TxValid & i_TxReady;
  // Reserved bits set, or a key-less command with no key ever loaded into the core
  assign cmd_bad  = (|i_RxData[7:2]) | (~i_RxData[1] & ~key_valid_q);
  assign cnt_last = (cnt_q == 4'd15);
  assign wdog_tc  = (wdog_q == WDW'(WDOG_MAX));

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) state_q <= ST_CMD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CMD:      if (rx_fire && !cmd_bad) state_d = i_RxData[1] ? ST_KEY : ST_TEXT;
      ST_KEY:      if (rx_fire && cnt_last) state_d = ST_TEXT;
      ST_TEXT:     if (rx_fire && cnt_last) state_d = has_key_q ? ST_CORE_RST : ST_START;
      ST_CORE_RST: state_d = ST_START;
      ST_START:    state_d = ST_WAIT;
      ST_WAIT: begin
        if (i_AesDone)    state_d = ST_SEND;
        else if (wdog_tc) state_d = ST_CMD;
      end
      ST_SEND:     if (tx_fire && cnt_last) state_d = ST_CMD;
      default:     state_d = ST_CMD;
    endcase
  end

  always_comb begin
    o_RxReady = 1'b0;
    o_TxValid = 1'b0;
    o_Busy    = 1'b1;
    case (state_q)
      ST_CMD:  begin o_RxReady = 1'b1; o_Busy = 1'b0; end
      ST_KEY:  o_RxReady = 1'b1;
      ST_TEXT: o_RxReady = 1'b1;
      ST_SEND: o_TxValid = 1'b1;
      default: ;
    endcase
  end

  // Core control lines are registered from the next state so they come straight off flops
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      err_q        <= 1'b0;
      start_q      <= 1'b0;
      core_rst_n_q <= 1'b1;
    end else begin
      err_q        <= (state_q == ST_CMD && rx_fire && cmd_bad) ||
                      (state_q == ST_WAIT && !i_AesDone && wdog_tc);
      start_q      <= (state_d == ST_START);
      core_rst_n_q <= (state_d != ST_CORE_RST);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      cnt_q       <= '0;
      wdog_q      <= '0;
      key_valid_q <= 1'b0;
      has_key_q   <= 1'b0;
      aes_enc_q   <= 1'b0;
      text_q      <= '0;
      key_q       <= '0;
      result_q    <= '0;
    end else begin
      case (state_q)
        ST_CMD: if (rx_fire && !cmd_bad) begin
          aes_enc_q <= i_RxData[0];
          has_key_q <= i_RxData[1];
          cnt_q     <= '0;
        end
        ST_KEY: if (rx_fire) begin
          key_q <= {key_q[119:0], i_RxData};
          cnt_q <= cnt_q + 4'd1;
          if (cnt_last) key_valid_q <= 1'b1;
        end
        ST_TEXT: if (rx_fire) begin
          text_q <= {text_q[119:0], i_RxData};
          cnt_q  <= cnt_q + 4'd1;
        end
        ST_START: wdog_q <= '0;
        ST_WAIT: begin
          wdog_q <= wdog_q + WDW'(1);
          if (i_AesDone)    result_q    <= i_AesData;
          else if (wdog_tc) key_valid_q <= 1'b0;
        end
        ST_SEND: if (tx_fire) begin
          result_q <= {result_q[119:0], 8'h00};
          cnt_q    <= cnt_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_TxData   = result_q[127:120];
  assign o_AesRst_n = i_Rst & core_rst_n_q;
  assign o_AesStart = start_q;
  assign o_AesEnc   = aes_enc_q;
  assign o_AesText  = text_q;
  assign o_AesKey   = key_q;
  assign o_Err      = err_q;

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// tb/tb_aes_stream_ctrl.sv - directed bench for aes_stream_ctrl with a behavioural stand-in for the AES core
module tb_aes_stream_ctrl;

  localparam int WDOG_MAX = 63;
  localparam logic [127:0] K  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         i_Clk = 0, i_Rst = 0;
  logic [7:0]   i_RxData = 0;
  logic         i_RxValid = 0, i_TxReady = 0;
  logic         o_RxReady, o_TxValid, o_AesRst_n, o_AesStart, o_AesEnc, o_Busy, o_Err;
  logic [7:0]   o_TxData;
  logic [127:0] o_AesText, o_AesKey;
  logic [127:0] i_AesData = 0;
  logic         i_AesDone = 0;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int err_cnt = 0, rst_cnt = 0, rst_cyc = 0, start_cnt = 0, start_cyc = 0;
  int txv_cyc = 0, done_cyc = 0, hold_err = 0, countdown = 0, acc_edge = 0;
  bit hold_on = 0, prev_txv = 0, core_en = 1;
  logic [127:0] cap_key = 0, cap_text = 0;
  logic         cap_enc = 0;

  aes_stream_ctrl #(.WDOG_MAX(WDOG_MAX)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_RxData(i_RxData), .i_RxValid(i_RxValid),
    .o_RxReady(o_RxReady), .o_TxData(o_TxData), .o_TxValid(o_TxValid), .i_TxReady(i_TxReady),
    .o_AesRst_n(o_AesRst_n), .o_AesStart(o_AesStart), .o_AesEnc(o_AesEnc),
    .o_AesText(o_AesText), .o_AesKey(o_AesKey), .i_AesData(i_AesData),
    .i_AesDone(i_AesDone), .o_Busy(o_Busy), .o_Err(o_Err)
  );

  always #5 i_Clk = ~i_Clk;
  always @(posedge i_Clk) cyc <= cyc + 1;

  function automatic logic [127:0] core_result(input logic enc, input logic [127:0] key,
                                               input logic [127:0] text);
    if (key == K && enc && text == PT)  return CT;
    if (key == K && !enc && text == CT) return PT;
    return 128'hdeadbeef;
  endfunction

  // Core stand-in and event recorder, all sampled on the falling edge
  always @(negedge i_Clk) begin
    if (!o_Busy) hold_on = 0;
    if (hold_on && (o_AesKey !== cap_key || o_AesText !== cap_text || o_AesEnc !== cap_enc))
      hold_err++;
    if (o_Err) err_cnt++;
    if (i_Rst && !o_AesRst_n) begin rst_cnt++; rst_cyc = cyc; end
    if (o_TxValid && !prev_txv) txv_cyc = cyc;
    prev_txv  = o_TxValid;
    i_AesDone = 0;
    if (o_AesStart) begin
      start_cnt++; start_cyc = cyc;
      cap_key = o_AesKey; cap_text = o_AesText; cap_enc = o_AesEnc;
      hold_on = 1;
      countdown = o_AesEnc ? 12 : 22;
    end else if (countdown > 0) begin
      countdown--;
      if (countdown == 0 && core_en) begin
        i_AesDone = 1;
        i_AesData = core_result(cap_enc, cap_key, cap_text);
        done_cyc  = cyc;
      end
    end
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    i_RxData = b; i_RxValid = 1;
    while (!o_RxReady && n < 200) begin @(negedge i_Clk); n++; end
    if (!o_RxReady) check_val("rx_ready_timeout", o_RxReady, 1);
    acc_edge = cyc;
    @(posedge i_Clk); @(negedge i_Clk);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input bit with_key,
                            input logic [127:0] key, input logic [127:0] text);
    send_byte(cmd);
    if (with_key) for (int i = 0; i < 16; i++) send_byte(key[127-8*i -: 8]);
    for (int i = 0; i < 16; i++) send_byte(text[127-8*i -: 8]);
    i_RxValid = 0;
  endtask

  task automatic recv16(input string tag, input logic [127:0] exp, input bit stall);
    int n = 0, k = 0, t = 0, stable_bad = 0;
    bit was_stalled = 0;
    logic [7:0] held = 0;
    while (!o_TxValid && n < 300) begin @(negedge i_Clk); n++; end
    check_val({tag, "_valid"}, o_TxValid, 1);
    while (k < 16 && t < 400) begin
      i_TxReady = !stall || (t >= 5 && (t % 2 == 1));
      if (was_stalled && (o_TxData !== held || !o_TxValid)) stable_bad++;
      if (o_TxValid && i_TxReady) begin
        check_val($sformatf("%s_byte%0d", tag, k), o_TxData, exp[127-8*k -: 8]);
        k++;
      end
      was_stalled = o_TxValid && !i_TxReady;
      held = o_TxData;
      @(posedge i_Clk); @(negedge i_Clk);
      t++;
    end
    i_TxReady = 0;
    check_val({tag, "_count"}, k, 16);
    check_val({tag, "_stable"}, stable_bad, 0);
    if (!stall) check_val({tag, "_cycles"}, t, 16);
    check_val({tag, "_busy_after"}, o_Busy, 0);
    check_val({tag, "_txv_after"}, o_TxValid, 0);
  endtask

  initial begin
    int r0, s0, last, n;
    repeat (3) @(negedge i_Clk);
    check_val("rst_rx_ready", o_RxReady, 1);
    check_val("rst_busy", o_Busy, 0);
    check_val("rst_txv", o_TxValid, 0);
    check_val("rst_txd", o_TxData, 0);
    check_val("rst_start", o_AesStart, 0);
    check_val("rst_enc", o_AesEnc, 0);
    check_val("rst_text", o_AesText, 0);
    check_val("rst_key", o_AesKey, 0);
    check_val("rst_err", o_Err, 0);
    check_val("rst_core_rst_n", o_AesRst_n, 0);
    i_Rst = 1;
    @(negedge i_Clk);

    send_byte(8'h01); i_RxValid = 0;
    check_val("err_nokey", o_Err, 1);
    check_val("err_nokey_busy", o_Busy, 0);
    @(negedge i_Clk);
    check_val("err_pulse_end", o_Err, 0);
    send_byte(8'h83); i_RxValid = 0;
    check_val("err_rsvd", o_Err, 1);
    check_val("err_rsvd_busy", o_Busy, 0);
    @(negedge i_Clk);

    r0 = rst_cnt; s0 = start_cnt;
    send_frame(8'h03, 1, K, PT);
    last = acc_edge;
    recv16("enc", CT, 0);
    check_val("enc_rst_pulses", rst_cnt - r0, 1);
    check_val("enc_rst_cycle", rst_cyc, last + 1);
    check_val("enc_start_pulses", start_cnt - s0, 1);
    check_val("enc_start_cycle", start_cyc, last + 2);
    check_val("enc_key", cap_key, K);
    check_val("enc_text", cap_text, PT);
    check_val("enc_mode", cap_enc, 1);
    check_val("enc_txv_latency", txv_cyc, done_cyc + 1);

    r0 = rst_cnt;
    send_frame(8'h00, 0, 128'h0, CT);
    last = acc_edge;
    recv16("dec", PT, 1);
    check_val("dec_no_core_rst", rst_cnt - r0, 0);
    check_val("dec_start_cycle", start_cyc, last + 1);
    check_val("dec_mode", cap_enc, 0);
    check_val("dec_key", cap_key, K);
    check_val("dec_text", cap_text, CT);
    check_val("hold_operands", hold_err, 0);

    core_en = 0;
    send_frame(8'h00, 0, 128'h0, PT);
    n = 0;
    while (!o_Err && n < 300) begin @(negedge i_Clk); n++; end
    check_val("wdog_err", o_Err, 1);
    check_val("wdog_cycles", cyc - start_cyc, WDOG_MAX + 2);
    check_val("wdog_busy", o_Busy, 0);
    core_en = 1;
    @(negedge i_Clk);
    send_byte(8'h01); i_RxValid = 0;
    check_val("wdog_keyvalid_cleared", o_Err, 1);
    @(negedge i_Clk);

    send_byte(8'h03);
    for (int i = 0; i < 8; i++) send_byte(K[127-8*i -: 8]);
    i_RxValid = 0;
    i_Rst = 0;
    #1;
    check_val("midrst_busy", o_Busy, 0);
    check_val("midrst_rx_ready", o_RxReady, 1);
    check_val("midrst_key", o_AesKey, 0);
    check_val("midrst_enc", o_AesEnc, 0);
    check_val("midrst_core_rst_n", o_AesRst_n, 0);
    check_val("midrst_txv", o_TxValid, 0);
    @(negedge i_Clk);
    i_Rst = 1;
    @(negedge i_Clk);
    send_frame(8'h03, 1, K, PT);
    recv16("post_rst_enc", CT, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
